// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg
//   Shared types and helpers for the universal shift register.
//   - shift_op_e : 3-bit command opcodes
//   - state_e    : control FSM states (IDLE, SHIFT)
//   - is_legal_op(): opcode legality. Rotates count as legal only when
//     UNIV_SHIFT_REG_ROTATE_EN is defined.
//   - is_shift_op(): opcode moves bits (one step per clock).
//
// Configuration macro: UNIV_SHIFT_REG_ROTATE_EN (enables ROL/ROR).

package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ASR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_ROR  = 3'd6,
        OP_RSV  = 3'd7
    } shift_op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Legal opcodes. Without rotate support, ROL/ROR fall into the
    // illegal group together with the reserved opcode.
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OP_NOP, OP_LOAD, OP_SHL, OP_SHR, OP_ASR: legal = 1'b1;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            OP_ROL, OP_ROR:                          legal = 1'b1;
`endif
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Opcodes that move bits; legality is checked separately.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/univ_shift_reg_shift_step.sv
// shift_step
//   Purely combinational single-step unit: moves the register by one bit
//   position according to op and reports the bit that leaves.
//   Ports:
//     op      in  3      opcode (shift_op_e encoding)
//     r       in  WIDTH  current register value
//     ser_i   in  1      serial fill bit (SHL/SHR only)
//     r_next  out WIDTH  register value after one step
//     ser_out out 1      bit that leaves the register in this step
//   Non-shift opcodes pass r through unchanged; the caller never commits
//   the result for them.
//
// Configuration macro: UNIV_SHIFT_REG_ROTATE_EN (rotate datapath only
// exists when defined).

module shift_step
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] r,
    input  logic             ser_i,
    output logic [WIDTH-1:0] r_next,
    output logic             ser_out
);

    always_comb begin
        r_next  = r;
        ser_out = 1'b0;
        case (op)
            OP_SHL: begin
                r_next  = {r[WIDTH-2:0], ser_i};
                ser_out = r[WIDTH-1];
            end
            OP_SHR: begin
                r_next  = {ser_i, r[WIDTH-1:1]};
                ser_out = r[0];
            end
            OP_ASR: begin
                // Sign bit is replicated; the fill bit plays no part.
                r_next  = {r[WIDTH-1], r[WIDTH-1:1]};
                ser_out = r[0];
            end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            OP_ROL: begin
                r_next  = {r[WIDTH-2:0], r[WIDTH-1]};
                ser_out = r[WIDTH-1];
            end
            OP_ROR: begin
                r_next  = {r[0], r[WIDTH-1:1]};
                ser_out = r[0];
            end
`endif
            default: begin
                r_next  = r;
                ser_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   WIDTH-bit universal shift register driven by a valid/ready command
//   interface. Supports parallel load, logical/arithmetic shifts and
//   (optionally) rotates by a programmable amount, one bit per clock.
//   Ports:
//     clk_i        in  1      clock, rising edge
//     rst_i        in  1      synchronous active-high reset
//     cmd_valid_i  in  1      command present
//     cmd_ready_o  out 1      idle; command accepted on valid & ready
//     cmd_op_i     in  3      opcode (shift_op_e)
//     cmd_amt_i    in  AW     shift amount, clamped to WIDTH
//     cmd_data_i   in  WIDTH  parallel load data
//     ser_i        in  1      serial fill bit, sampled live every step
//     par_o        out WIDTH  register contents
//     ser_o        out 1      bit that left in the most recent step
//     busy_o       out 1      ~cmd_ready_o
//     done_o       out 1      one-cycle completion pulse
//     err_o        out 1      one-cycle illegal-opcode pulse (with done_o)
//
// Configuration macro: UNIV_SHIFT_REG_ROTATE_EN (ROL/ROR legal when set,
// otherwise they complete as illegal opcodes).

module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [AW-1:0]    cmd_amt_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] par_o,
    output logic             ser_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    state_e           state_reg, state_next;
    logic [2:0]       op_reg, op_next;
    logic [AW-1:0]    remaining_reg, remaining_next;
    logic [WIDTH-1:0] par_reg, par_next;
    logic             ser_reg, ser_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    logic             accept;
    logic [AW-1:0]    amt_clamped;
    logic [2:0]       step_op;
    logic [WIDTH-1:0] step_r;
    logic             step_bit;

    assign accept = cmd_valid_i && (state_reg == ST_IDLE);

    // Clamp once at accept so the step counter never has to wrap.
    assign amt_clamped = (cmd_amt_i > AW'(WIDTH)) ? AW'(WIDTH) : cmd_amt_i;

    // The first step runs at the accept edge straight from the command
    // inputs; later steps use the latched opcode.
    assign step_op = (state_reg == ST_IDLE) ? cmd_op_i : op_reg;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op      (step_op),
        .r       (par_reg),
        .ser_i   (ser_i),
        .r_next  (step_r),
        .ser_out (step_bit)
    );

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        remaining_next = remaining_reg;
        par_next       = par_reg;
        ser_next       = ser_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    // Single-cycle completion unless a multi-step shift
                    // is started below.
                    done_next = 1'b1;
                    if (!is_legal_op(cmd_op_i)) begin
                        err_next = 1'b1;
                    end else if (cmd_op_i == OP_LOAD) begin
                        par_next = cmd_data_i;
                    end else if (is_shift_op(cmd_op_i) && (amt_clamped != '0)) begin
                        par_next = step_r;
                        ser_next = step_bit;
                        if (amt_clamped > AW'(1)) begin
                            state_next     = ST_SHIFT;
                            op_next        = cmd_op_i;
                            remaining_next = amt_clamped - AW'(1);
                            done_next      = 1'b0;
                        end
                    end
                end
            end
            ST_SHIFT: begin
                par_next       = step_r;
                ser_next       = step_bit;
                remaining_next = remaining_reg - AW'(1);
                if (remaining_reg == AW'(1)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_NOP;
            remaining_reg <= '0;
            par_reg       <= '0;
            ser_reg       <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            remaining_reg <= remaining_next;
            par_reg       <= par_next;
            ser_reg       <= ser_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign cmd_ready_o = (state_reg == ST_IDLE);
    assign busy_o      = ~cmd_ready_o;
    assign par_o       = par_reg;
    assign ser_o       = ser_reg;
    assign done_o      = done_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg
//   Self-checking bench for univ_shift_reg (WIDTH = 8). Commands are driven
//   by tasks that predict the per-cycle outputs with an arithmetic model;
//   a single negedge process compares every output against the prediction.
//   Honours UNIV_SHIFT_REG_ROTATE_EN for rotate expectations.

module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [2:0]    cmd_op_i;
    logic [AW-1:0] cmd_amt_i;
    logic [W-1:0]  cmd_data_i;
    logic          ser_i;
    logic [W-1:0]  par_o;
    logic          ser_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_amt_i   (cmd_amt_i),
        .cmd_data_i  (cmd_data_i),
        .ser_i       (ser_i),
        .par_o       (par_o),
        .ser_o       (ser_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    int   n_vec  = 0;
    int   n_miss = 0;
    bit   check_en = 1'b0;
    bit   rot_en;

    logic [W-1:0] exp_par;
    logic         exp_ser, exp_ready, exp_done, exp_err;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    initial rot_en = 1'b1;
`else
    initial rot_en = 1'b0;
`endif

    // Per-cycle compare of every output against the model's prediction.
    always @(negedge clk) begin
        if (check_en) begin
            n_vec++;
            if ({par_o, ser_o, cmd_ready_o, busy_o, done_o, err_o} !==
                {exp_par, exp_ser, exp_ready, ~exp_ready, exp_done, exp_err}) begin
                n_miss++;
                $display("FAIL cycle_cmp t=%0t par=%h want %h ser=%b want %b rdy=%b want %b busy=%b done=%b want %b err=%b want %b",
                         $time, par_o, exp_par, ser_o, exp_ser, cmd_ready_o, exp_ready,
                         busy_o, done_o, exp_done, err_o, exp_err);
            end
        end
    end

    task automatic lit(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s got %h want %h", name, act, req);
        end
    endtask

    // One step computed with integer arithmetic; returns {out_bit, value}.
    function automatic logic [W:0] model_step(input int op, input logic [W-1:0] r, input logic fill);
        int v;
        int res;
        int o;
        v   = int'(r);
        res = v;
        o   = 0;
        case (op)
            2: begin res = (v * 2) + int'(fill);               o = v / 128; end
            3: begin res = (v / 2) + int'(fill) * 128;         o = v % 2;   end
            4: begin res = (v / 2) + (v >= 128 ? 128 : 0);     o = v % 2;   end
            5: begin res = (v * 2) + (v / 128);                o = v / 128; end
            6: begin res = (v / 2) + (v % 2) * 128;            o = v % 2;   end
            default: begin res = v; o = 0; end
        endcase
        res = res % 256;
        return {o[0], res[W-1:0]};
    endfunction

    task automatic do_reset(input int cycles, input bit with_cmd);
        rst_i       = 1'b1;
        cmd_valid_i = with_cmd;
        cmd_op_i    = 3'd1;
        cmd_amt_i   = 4'd3;
        cmd_data_i  = 8'hFF;
        repeat (cycles) begin
            @(posedge clk); #1;
            exp_par = '0; exp_ser = 1'b0; exp_ready = 1'b1;
            exp_done = 1'b0; exp_err = 1'b0;
            check_en = 1'b1;
        end
        rst_i       = 1'b0;
        cmd_valid_i = 1'b0;
        $display("reset cycles=%0d with_cmd=%0d -> par=%h", cycles, with_cmd, par_o);
    endtask

    task automatic idle_cycle();
        cmd_valid_i = 1'b0;
        ser_i       = 1'($urandom);
        @(posedge clk); #1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Issue one command (bench is idle on entry) and track it to the done
    // cycle. abort_at > 0 asserts reset after that many steps.
    task automatic do_cmd(input logic [2:0] op, input logic [AW-1:0] amt,
                          input logic [W-1:0] data, input logic [15:0] fill,
                          input int abort_at);
        int n;
        bit legal;
        logic [W:0] st;
        n     = (int'(amt) > W) ? W : int'(amt);
        legal = (op <= 3'd4) || (rot_en && (op == 3'd5 || op == 3'd6));
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_amt_i   = amt;
        cmd_data_i  = data;
        ser_i       = fill[0];
        if (legal && op >= 3'd2 && n > 0) begin
            for (int k = 0; k < n; k++) begin
                if (k > 0) begin
                    // Junk on the command port while busy must be ignored.
                    ser_i       = fill[k];
                    cmd_valid_i = 1'($urandom);
                    cmd_op_i    = 3'($urandom);
                    cmd_amt_i   = 4'($urandom);
                    cmd_data_i  = 8'($urandom);
                end
                st = model_step(int'(op), exp_par, fill[k]);
                @(posedge clk); #1;
                exp_par   = st[W-1:0];
                exp_ser   = st[W];
                exp_ready = (k == n - 1);
                exp_done  = (k == n - 1);
                exp_err   = 1'b0;
                if (abort_at > 0 && k + 1 == abort_at && k < n - 1) begin
                    $display("cmd op=%0d amt=%0d aborted after %0d steps", op, amt, abort_at);
                    do_reset(1, 1'b0);
                    return;
                end
            end
        end else begin
            @(posedge clk); #1;
            if (legal && op == 3'd1) exp_par = data;
            exp_ready = 1'b1;
            exp_done  = 1'b1;
            exp_err   = !legal;
        end
        cmd_valid_i = 1'b0;
        $display("cmd op=%0d amt=%0d data=%h fill=%h -> par=%h ser=%b err=%b",
                 op, amt, data, fill, par_o, ser_o, err_o);
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_amt_i = '0;
        cmd_data_i = '0; ser_i = 1'b0;
        exp_par = '0; exp_ser = 1'b0; exp_ready = 1'b1; exp_done = 1'b0; exp_err = 1'b0;

        do_reset(2, 1'b0);
        lit("reset_par", par_o, 8'h00);
        lit("reset_ready", {7'd0, cmd_ready_o}, 8'h01);

        // LOAD 0xA5, then SHL 3 with fill 1, then back-to-back NOP.
        do_cmd(3'd1, 4'd0, 8'hA5, 16'h0000, 0);
        lit("load_a5", par_o, 8'hA5);
        lit("load_done", {7'd0, done_o}, 8'h01);
        idle_cycle();
        do_cmd(3'd2, 4'd3, 8'h00, 16'hFFFF, 0);
        lit("shl3_par", par_o, 8'h2F);
        lit("shl3_model", exp_par, 8'h2F);
        lit("shl3_ser", {7'd0, ser_o}, 8'h01);
        do_cmd(3'd0, 4'd5, 8'h33, 16'h0000, 0);
        lit("nop_b2b_par", par_o, 8'h2F);

        // ASR and clamped SHR.
        do_cmd(3'd1, 4'd0, 8'h80, 16'h0000, 0);
        do_cmd(3'd4, 4'd2, 8'h00, 16'hFFFF, 0);
        lit("asr2_par", par_o, 8'hE0);
        lit("asr2_ser", {7'd0, ser_o}, 8'h00);
        do_cmd(3'd3, 4'd15, 8'h00, 16'h0000, 0);
        lit("shr15_par", par_o, 8'h00);

        // Rotate (build dependent) and reserved opcode.
        do_cmd(3'd1, 4'd0, 8'h01, 16'h0000, 0);
        do_cmd(3'd6, 4'd1, 8'h00, 16'h0000, 0);
        lit("ror1_par", par_o, rot_en ? 8'h80 : 8'h01);
        lit("ror1_err", {7'd0, err_o}, rot_en ? 8'h00 : 8'h01);
        idle_cycle();
        do_cmd(3'd7, 4'd2, 8'h00, 16'h0000, 0);
        lit("op7_err", {7'd0, err_o}, 8'h01);

        // Abort SHL 8 on 0xFF after 3 steps; reset wins over an accept.
        do_cmd(3'd1, 4'd0, 8'hFF, 16'h0000, 0);
        do_cmd(3'd2, 4'd8, 8'h00, 16'h0000, 3);
        lit("abort_par", par_o, 8'h00);
        do_cmd(3'd1, 4'd0, 8'h5A, 16'h0000, 0);
        do_reset(1, 1'b1);
        lit("rst_prio_par", par_o, 8'h00);

        // Random command stream.
        for (int i = 0; i < 250; i++) begin
            logic [2:0]  r_op;
            logic [3:0]  r_amt;
            int          r_abort;
            r_op    = 3'($urandom_range(0, 7));
            r_amt   = 4'($urandom_range(0, 15));
            r_abort = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 8) : 0;
            do_cmd(r_op, r_amt, 8'($urandom), 16'($urandom), r_abort);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
